// File: rtl/dma_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_sequencer
// Description : Splits a DMA job (start address, byte length) into AXI-style
//               read bursts of 8-byte beats. Bursts are at most 16 beats and
//               never cross a 4 KiB boundary. A configurable number of bursts
//               may be in flight before issue stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_burst_sequencer #(
  parameter int NREG   = 4,
  parameter int W      = 32,
  parameter int MAXOUT = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                CONFIG_VALID,
  output logic                CONFIG_READY,
  input  logic [NREG*W-1:0]   CONFIG_DATA,
  output logic                CMD_VALID,
  input  logic                CMD_READY,
  output logic [31:0]         CMD_ADDR,
  output logic [7:0]          CMD_LEN,
  input  logic                DONE_VALID,
  output logic                ERR
);

  localparam logic [3:0] c_maxout = 4'(MAXOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [31:0] r_remain;
  logic [3:0]  r_outstanding;
  logic        r_err;

  logic [31:0] w_word1;
  logic [31:0] w_word3;
  logic        w_accept;
  logic        w_bad;
  logic [28:0] w_rem_beats;
  logic [9:0]  w_bnd_beats;
  logic [4:0]  w_beats;
  logic [31:0] w_burst_bytes;
  logic        w_hs;
  logic        w_done_eff;
  logic [3:0]  w_out_next;
  logic        w_unused_cfg;

  // Only words 1 and 3 carry meaning; the rest of the bus is deliberately ignored.
  assign w_word1      = 32'(CONFIG_DATA[1*W +: W]);
  assign w_word3      = 32'(CONFIG_DATA[3*W +: W]);
  assign w_unused_cfg = ^CONFIG_DATA;

  assign w_accept = CONFIG_VALID && CONFIG_READY;
  // Zero length or any misalignment to the 8-byte beat makes the job unusable.
  assign w_bad    = (w_word3 == 32'd0) || (w_word1[2:0] != 3'd0) || (w_word3[2:0] != 3'd0);

  // Burst size: smallest of remaining beats, 16, and beats left before the 4 KiB line.
  always_comb begin
    w_rem_beats = r_remain[31:3];
    w_bnd_beats = 10'd512 - {1'b0, r_addr[11:3]};
    w_beats     = 5'd16;
    if (w_rem_beats < 29'd16) begin
      w_beats = w_rem_beats[4:0];
    end
    if (w_bnd_beats < {5'd0, w_beats}) begin
      w_beats = w_bnd_beats[4:0];
    end
    w_burst_bytes = {24'd0, w_beats, 3'b000};
  end

  assign w_hs       = CMD_VALID && CMD_READY;
  // A completion with nothing outstanding is stale (e.g. from before a reset).
  assign w_done_eff = DONE_VALID && (r_outstanding != 4'd0);

  // Outstanding count: simultaneous issue and completion cancel out.
  always_comb begin
    w_out_next = r_outstanding;
    case ({w_hs, w_done_eff})
      2'b10:   w_out_next = r_outstanding + 4'd1;
      2'b01:   w_out_next = r_outstanding - 4'd1;
      default: w_out_next = r_outstanding;
    endcase
  end

  // Next state and outputs; outputs depend on registered state only.
  always_comb begin
    w_state_next = r_state;
    CONFIG_READY = (r_state == S_IDLE);
    CMD_VALID    = (r_state == S_ISSUE) && (r_outstanding < c_maxout);
    CMD_ADDR     = r_addr;
    CMD_LEN      = {3'd0, w_beats - 5'd1};
    ERR          = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_bad) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_hs && (r_remain == w_burst_bytes)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_next == 4'd0) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Job cursor: loaded on acceptance, advanced by one burst per handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_addr   <= 32'd0;
      r_remain <= 32'd0;
    end else if (w_accept) begin
      r_addr   <= w_word1;
      r_remain <= w_word3;
    end else if (w_hs) begin
      r_addr   <= r_addr + w_burst_bytes;
      r_remain <= r_remain - w_burst_bytes;
    end
  end

  // In-flight burst counter and the one-cycle reject pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_outstanding <= 4'd0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_err         <= w_accept && w_bad;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_burst_sequencer
// Description : Table-driven jobs plus hand-written multi-cycle sequences
//               (outstanding limit, random stalls, reset mid-job).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_burst_sequencer;

  localparam int NREG   = 4;
  localparam int W      = 32;
  localparam int MAXOUT = 8;

  logic               ACLK;
  logic               ARESETN;
  logic               CONFIG_VALID;
  logic               CONFIG_READY;
  logic [NREG*W-1:0]  CONFIG_DATA;
  logic               CMD_VALID;
  logic               CMD_READY;
  logic [31:0]        CMD_ADDR;
  logic [7:0]         CMD_LEN;
  logic               DONE_VALID;
  logic               ERR;

  dma_burst_sequencer #(.NREG(NREG), .W(W), .MAXOUT(MAXOUT)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .CONFIG_VALID (CONFIG_VALID),
    .CONFIG_READY (CONFIG_READY),
    .CONFIG_DATA  (CONFIG_DATA),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_ADDR     (CMD_ADDR),
    .CMD_LEN      (CMD_LEN),
    .DONE_VALID   (DONE_VALID),
    .ERR          (ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          exp_err;
    int          exp_ncmd;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] an;
    logic [7:0]  ln;
  } vec_t;

  vec_t vtab [9];

  int n_vec = 0;
  int n_err = 0;

  int          res_ncmd;
  int          res_errcnt;
  int          res_maxout;
  int          res_last_done;
  int          res_ready_cyc;
  logic [31:0] res_bytes;
  logic [31:0] res_a0;
  logic [31:0] res_an;
  logic [7:0]  res_l0;
  logic [7:0]  res_ln;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference burst length: min(remaining beats, 16, beats to the 4 KiB line) - 1.
  function automatic logic [7:0] exp_len(input logic [31:0] a, input logic [31:0] rem);
    int b;
    int bnd;
    b = int'(rem >> 3);
    if (b > 16) b = 16;
    bnd = (4096 - int'(a[11:0])) / 8;
    if (bnd < b) b = bnd;
    return 8'(b - 1);
  endfunction

  task automatic load_job(input logic [31:0] a, input logic [31:0] l);
    CONFIG_DATA          = '0;
    CONFIG_DATA[1*W +: W] = a;
    CONFIG_DATA[3*W +: W] = l;
    CONFIG_DATA[0 +: W]   = 32'hDEAD_BEEF;
    CONFIG_DATA[2*W +: W] = 32'hFFFF_FFFF;
  endtask

  // Runs one job to completion; rnd selects random READY/DONE, else READY=1 and DONE 2 cycles after each command.
  task automatic run_job(input logic [31:0] a, input logic [31:0] l, input bit rnd);
    logic [31:0] m_addr;
    logic [31:0] m_rem;
    logic [31:0] bytes;
    logic [31:0] st_addr;
    logic [7:0]  st_len;
    logic [7:0]  el;
    int          pend[$];
    int          myout;
    bit          stalled;
    bit          dn;
    bit          fin;
    res_ncmd = 0; res_errcnt = 0; res_maxout = 0; res_last_done = -1;
    res_ready_cyc = -1; res_bytes = 0;
    res_a0 = 0; res_an = 0; res_l0 = 0; res_ln = 0;
    m_addr = a; m_rem = l; myout = 0; stalled = 0; fin = 0; st_addr = 0; st_len = 0;
    load_job(a, l);
    CONFIG_VALID = 1'b1;
    CMD_READY    = 1'b1;
    DONE_VALID   = 1'b0;
    check("cfg_ready_before_job", 32'(CONFIG_READY), 32'd1);
    tick();
    CONFIG_VALID = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (ERR) res_errcnt++;
      if (CONFIG_READY) begin
        fin = 1;
        res_ready_cyc = cyc;
        DONE_VALID = 1'b0;
      end else begin
        CMD_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rnd) dn = (myout > 0) && ($urandom_range(0, 1) == 1);
        else     dn = (pend.size() > 0) && (pend[0] == cyc);
        if (dn && !rnd) pend.delete(0);
        DONE_VALID = dn;
        if (dn) res_last_done = cyc;
        check("cmd_valid", 32'(CMD_VALID), 32'((m_rem != 0) && (myout < MAXOUT)));
        if (stalled) begin
          check("stall_addr", CMD_ADDR, st_addr);
          check("stall_len", 32'(CMD_LEN), 32'(st_len));
        end
        stalled = 0;
        if (CMD_VALID) begin
          el = exp_len(m_addr, m_rem);
          check("cmd_addr", CMD_ADDR, m_addr);
          check("cmd_len", 32'(CMD_LEN), 32'(el));
          if (CMD_READY) begin
            if (res_ncmd == 0) begin
              res_a0 = CMD_ADDR;
              res_l0 = CMD_LEN;
            end
            res_an = CMD_ADDR;
            res_ln = CMD_LEN;
            res_ncmd++;
            bytes = (32'(el) + 32'd1) << 3;
            m_addr    = m_addr + bytes;
            m_rem     = m_rem - bytes;
            res_bytes = res_bytes + bytes;
            myout++;
            pend.push_back(cyc + 2);
          end else begin
            stalled = 1;
            st_addr = CMD_ADDR;
            st_len  = CMD_LEN;
          end
        end
        if (dn) myout--;
        if (myout > res_maxout) res_maxout = myout;
      end
      tick();
    end
    if (!fin) check("job_timeout", 32'd0, 32'd1);
    DONE_VALID = 1'b0;
    // Two idle cycles catch a stray second ERR pulse or a command issued from idle.
    repeat (2) begin
      if (ERR) res_errcnt++;
      if (CMD_VALID) res_ncmd++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    int  myout;
    bit  hs;
    bit  dn;
    bit  fin;

    vtab[0] = '{32'h0000_1000, 32'd256,  0, 2, 32'h0000_1000, 8'd15, 32'h0000_1080, 8'd15};
    vtab[1] = '{32'h0000_1FC0, 32'd128,  0, 2, 32'h0000_1FC0, 8'd7,  32'h0000_2000, 8'd7};
    vtab[2] = '{32'h0000_0000, 32'd8,    0, 1, 32'h0000_0000, 8'd0,  32'h0000_0000, 8'd0};
    vtab[3] = '{32'h0000_0FF8, 32'd24,   0, 2, 32'h0000_0FF8, 8'd0,  32'h0000_1000, 8'd1};
    vtab[4] = '{32'h0000_0000, 32'd0,    1, 0, 32'h0,         8'd0,  32'h0,         8'd0};
    vtab[5] = '{32'h0000_1004, 32'd64,   1, 0, 32'h0,         8'd0,  32'h0,         8'd0};
    vtab[6] = '{32'h0000_1000, 32'd12,   1, 0, 32'h0,         8'd0,  32'h0,         8'd0};
    vtab[7] = '{32'hFFFF_FFF8, 32'd16,   0, 2, 32'hFFFF_FFF8, 8'd0,  32'h0000_0000, 8'd0};
    vtab[8] = '{32'h0000_0100, 32'd1000, 0, 8, 32'h0000_0100, 8'd15, 32'h0000_0480, 8'd12};

    ARESETN = 1'b0; CONFIG_VALID = 1'b0; CONFIG_DATA = '0;
    CMD_READY = 1'b1; DONE_VALID = 1'b0;
    tick();
    check("reset_cfg_ready", 32'(CONFIG_READY), 32'd1);
    check("reset_cmd_valid", 32'(CMD_VALID), 32'd0);
    check("reset_err", 32'(ERR), 32'd0);
    tick();
    ARESETN = 1'b1;
    tick();

    // Directed job table.
    for (int i = 0; i < 9; i++) begin
      run_job(vtab[i].addr, vtab[i].len, 1'b0);
      check($sformatf("v%0d_err", i), 32'(res_errcnt), 32'(vtab[i].exp_err));
      check($sformatf("v%0d_ncmd", i), 32'(res_ncmd), 32'(vtab[i].exp_ncmd));
      if (vtab[i].exp_ncmd > 0) begin
        check($sformatf("v%0d_first_addr", i), res_a0, vtab[i].a0);
        check($sformatf("v%0d_first_len", i), 32'(res_l0), 32'(vtab[i].l0));
        check($sformatf("v%0d_last_addr", i), res_an, vtab[i].an);
        check($sformatf("v%0d_last_len", i), 32'(res_ln), 32'(vtab[i].ln));
        check($sformatf("v%0d_bytes", i), res_bytes, vtab[i].len);
        check($sformatf("v%0d_ready_after_done", i), 32'(res_ready_cyc - res_last_done), 32'd1);
      end
    end

    // Outstanding limit: DONE withheld, exactly MAXOUT commands then stall.
    load_job(32'h0, 32'd2048);
    CONFIG_VALID = 1'b1; CMD_READY = 1'b1; DONE_VALID = 1'b0;
    tick();
    CONFIG_VALID = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (CMD_VALID) begin
        check("maxout_addr", CMD_ADDR, 32'(cnt * 128));
        cnt++;
      end
      tick();
    end
    check("maxout_ncmd", 32'(cnt), 32'(MAXOUT));
    check("maxout_stalled_valid", 32'(CMD_VALID), 32'd0);
    DONE_VALID = 1'b1;
    tick();
    DONE_VALID = 1'b0;
    check("ninth_valid", 32'(CMD_VALID), 32'd1);
    check("ninth_addr", CMD_ADDR, 32'h0000_0400);
    myout = MAXOUT - 1;
    fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (CONFIG_READY) begin
        fin = 1;
        DONE_VALID = 1'b0;
      end else begin
        CMD_READY  = 1'b1;
        dn         = (myout > 0);
        DONE_VALID = dn;
        hs         = CMD_VALID;
        if (hs) cnt++;
        tick();
        myout = myout + int'(hs) - int'(dn);
      end
    end
    DONE_VALID = 1'b0;
    check("maxout_total_cmds", 32'(cnt), 32'd16);
    check("maxout_back_idle", 32'(CONFIG_READY), 32'd1);

    // Random READY stalls with coincident DONE and handshake.
    run_job(32'h0, 32'd2048, 1'b1);
    check("rnd0_ncmd", 32'(res_ncmd), 32'd16);
    check("rnd0_err", 32'(res_errcnt), 32'd0);
    check("rnd0_maxout_ok", 32'(res_maxout <= MAXOUT), 32'd1);
    run_job(32'h0000_0F40, 32'd512, 1'b1);
    check("rnd1_ncmd", 32'(res_ncmd), 32'd5);
    check("rnd1_bytes", res_bytes, 32'd512);

    // Reset mid-job with three bursts outstanding.
    load_job(32'h0, 32'd2048);
    CONFIG_VALID = 1'b1; CMD_READY = 1'b1; DONE_VALID = 1'b0;
    tick();
    CONFIG_VALID = 1'b0;
    cnt = 0;
    repeat (3) begin
      if (CMD_VALID) cnt++;
      tick();
    end
    check("rst_mid_cmds", 32'(cnt), 32'd3);
    check("rst_mid_valid_before", 32'(CMD_VALID), 32'd1);
    ARESETN = 1'b0;
    #1;
    check("rst_mid_cmd_valid", 32'(CMD_VALID), 32'd0);
    check("rst_mid_cfg_ready", 32'(CONFIG_READY), 32'd1);
    tick();
    ARESETN = 1'b1;
    DONE_VALID = 1'b1;
    tick();
    tick();
    DONE_VALID = 1'b0;
    run_job(32'h0000_1000, 32'd256, 1'b0);
    check("post_rst_ncmd", 32'(res_ncmd), 32'd2);
    check("post_rst_err", 32'(res_errcnt), 32'd0);
    check("post_rst_last_addr", res_an, 32'h0000_1080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
